// File: rtl/dline_xfer.sv
// rtl/dline_xfer.sv - cache line transfer engine over a 4-bit quad-SPI style memory bus (option: DLINE_XFER_DUMMY_EN)
module dline_xfer #(
    parameter int          LINE_LENGTH = 4,
    parameter int          PA          = 22,
    parameter logic [7:0]  CMD_READ    = 8'hEB,
    parameter logic [7:0]  CMD_WRITE   = 8'h38,
    parameter int          DUMMY       = 6
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                req,
    input  logic                                push,
    input  logic                                pull,
    input  logic [PA-$clog2(LINE_LENGTH)-1:0]   tag,
    output logic                                busy,
    output logic                                done,
    input  logic [3:0]                          dwrite,
    output logic [3:0]                          dread,
    output logic                                rstrobe_d,
    output logic                                wstrobe_d,
    output logic                                q_cs_n,
    output logic                                q_sck_en,
    output logic [3:0]                          q_out,
    output logic                                q_oe,
    input  logic [3:0]                          q_in
);

    localparam int OW   = $clog2(LINE_LENGTH);
    localparam int NIBS = 2 * LINE_LENGTH;
    localparam int CW   = $clog2((NIBS > 16) ? NIBS : 16);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WAIT,
        S_DATA,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_next;
    logic           is_push;
    logic [31:0]    hdr_sh;
    logic [3:0]     q_data;
    logic [23:0]    addr24;
    logic           accept;
    logic           pull_data;

    // Byte address of the line: tag followed by zero offset bits, zero-extended.
    assign addr24    = 24'({tag, {OW{1'b0}}});
    assign accept    = (state == S_IDLE) && req && (push || pull);
    assign pull_data = (state == S_DATA) && !is_push;

    // Next-state sequencing and the bus/cache-facing outputs decoded from the phase.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        busy       = 1'b1;
        done       = 1'b0;
        q_cs_n     = 1'b0;
        q_sck_en   = 1'b1;
        q_oe       = 1'b0;
        q_out      = 4'h0;
        rstrobe_d  = 1'b0;
        case (state)
            S_IDLE: begin
                busy     = 1'b0;
                q_cs_n   = 1'b1;
                q_sck_en = 1'b0;
                cnt_next = '0;
                if (accept) begin
                    state_next = S_CMD;
                end
            end
            S_CMD: begin
                q_oe  = 1'b1;
                q_out = hdr_sh[31:28];
                if (cnt == CW'(1)) begin
                    state_next = S_ADDR;
                    cnt_next   = '0;
                end
            end
            S_ADDR: begin
                q_oe  = 1'b1;
                q_out = hdr_sh[31:28];
                if (cnt == CW'(5)) begin
                    // Push fetches its first nibble one cycle ahead of DATA.
                    rstrobe_d = is_push;
                    cnt_next  = '0;
                    if (is_push) begin
                        state_next = S_DATA;
                    end else begin
`ifdef DLINE_XFER_DUMMY_EN
                        state_next = S_WAIT;
`else
                        state_next = S_DATA;
`endif
                    end
                end
            end
            S_WAIT: begin
                if (cnt == CW'(DUMMY - 1)) begin
                    state_next = S_DATA;
                    cnt_next   = '0;
                end
            end
            S_DATA: begin
                q_oe      = is_push;
                q_out     = is_push ? q_data : 4'h0;
                rstrobe_d = is_push && (cnt != CW'(NIBS - 1));
                if (cnt == CW'(NIBS - 1)) begin
                    state_next = S_DONE;
                    cnt_next   = '0;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                q_cs_n     = 1'b1;
                q_sck_en   = 1'b0;
                state_next = S_IDLE;
                cnt_next   = '0;
            end
            default: begin
                busy       = 1'b0;
                q_cs_n     = 1'b1;
                q_sck_en   = 1'b0;
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Phase register, request latch, header shifter and data-path registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            is_push   <= 1'b0;
            hdr_sh    <= '0;
            q_data    <= 4'h0;
            dread     <= 4'h0;
            wstrobe_d <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                is_push <= push;
                hdr_sh  <= {(push ? CMD_WRITE : CMD_READ), addr24};
            end else if ((state == S_CMD) || (state == S_ADDR)) begin
                hdr_sh <= {hdr_sh[27:0], 4'h0};
            end
            if (rstrobe_d) begin
                q_data <= dwrite;
            end
            if (pull_data) begin
                dread <= q_in;
            end
            // The fill strobe trails the memory sample by one cycle, so the last one lands in DONE.
            wstrobe_d <= pull_data;
        end
    end

endmodule

// File: doc/dline_xfer.md
# dline_xfer

Line-transfer engine on the memory side of the data cache. When the cache reports a miss, it moves one cache line over a 4-bit quad-SPI style memory bus. A push (write-back) reads the line nibble by nibble from the cache's `dwrite` port. A pull (fill) streams memory nibbles into the cache's `dread` port. It generates the `rstrobe_d`/`wstrobe_d` pulse trains the cache uses to step its line offset.

## Interface
Parameters:
- `LINE_LENGTH`, 4, cache line length in bytes; one line is 2*LINE_LENGTH nibbles.
- `PA`, 22, physical address width.
- `CMD_READ`, 8'hEB, memory read command byte.
- `CMD_WRITE`, 8'h38, memory write command byte.
- `DUMMY`, 6, read wait cycles between address and data (1..15).

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low; `reset==0` at a rising edge resets the block.
- `req`  in  1  start request, sampled only in IDLE.
- `push`  in  1  write line back (from cache).
- `pull`  in  1  fill line (from cache).
- `tag`  in  PA-log2(LINE_LENGTH)  line address (from cache).
- `busy`  out  1  high from the cycle after an accepted `req` through DONE.
- `done`  out  1  one-cycle pulse at end of transfer.
- `dwrite`  in  4  cache nibble for push; combinational from the cache offset.
- `dread`  out  4  fill nibble to cache.
- `rstrobe_d`  out  1  push strobe; cache advances offset.
- `wstrobe_d`  out  1  fill strobe; cache writes `dread` and advances offset.
- `q_cs_n`  out  1  memory chip select, active low.
- `q_sck_en`  out  1  memory clock enable; one nibble per `clk` while high.
- `q_out`  out  4  nibble to memory.
- `q_oe`  out  1  drive `q_out` onto the pads.
- `q_in`  in  4  nibble from memory.

## Operation
- Reset values:
  - `q_cs_n`=1.
  - `q_sck_en`, `q_oe`, `busy`, `done`, `rstrobe_d` and `wstrobe_d` = 0.
  - `q_out` and `dread` = 0.
  - State IDLE.
- Request acceptance:
  - IDLE accepts `req` when `push|pull`. `push` wins if both are high.
  - `req` with neither flag is dropped.
  - On acceptance the block latches the direction and `tag`. `req` is ignored while busy.
- Byte address is `{tag, log2(LINE_LENGTH) zero bits}`, zero-extended to 24 bits.
- States:
  - IDLE: waits for an accepted `req`.
  - CMD: 2 nibbles, command MSB first, `q_oe`=1.
  - ADDR: 6 nibbles, MSB first, `q_oe`=1.
  - WAIT: DUMMY cycles, pull only, `q_oe`=0.
  - DATA: 2*LINE_LENGTH nibbles.
  - DONE: `q_cs_n`=1, `done`=1, for 1 cycle, then IDLE.
- `q_cs_n`=0 and `q_sck_en`=1 throughout CMD, ADDR, WAIT and DATA.
- Push DATA:
  - Strobes are fetched one cycle ahead of the memory phase.
  - `rstrobe_d`=1 in the last ADDR cycle and the first 2*LINE_LENGTH-1 DATA cycles. That is 2*LINE_LENGTH contiguous strobes.
  - `q_out` registers `dwrite` on each strobe cycle. Memory sees byte0[7:4], byte0[3:0], byte1[7:4], and so on.
  - `q_oe`=1.
- Pull DATA:
  - `q_oe`=0. `q_in` is sampled every DATA cycle into `dread`.
  - `wstrobe_d`=1 in the following cycle. The 2*LINE_LENGTH strobes are contiguous and the last one falls in DONE.
  - Nibble order matches push: high nibble of byte 0 first.
- Strobes are never broken inside a line, because the cache resets its offset on any strobe-free cycle.
- The core holds `paddr` stable while `busy`; the block does not re-check `push`/`pull`/`tag` after acceptance.

## Timing
- `req` is accepted at edge 0.
- CMD occupies cycles 1-2 and ADDR occupies cycles 3-8.
- Push:
  - DATA occupies cycles 9-16 for LINE_LENGTH=4.
  - `rstrobe_d` is high in cycles 8-15.
  - DONE is cycle 17.
- Pull:
  - WAIT occupies cycles 9-14 and DATA occupies cycles 15-22.
  - `wstrobe_d` is high in cycles 16-23.
  - DONE is cycle 23.
- `req` may be re-asserted in the cycle after DONE. The minimum `q_cs_n` high time is 1 cycle.
- Reset mid-transfer: the block returns to IDLE at that edge with `q_cs_n`=1 and strobes low. The partial line is abandoned and the cache offset falls to 0. No `done` pulse is generated.

## Configuration
- `DLINE_XFER_DUMMY_EN` defined: pulls include the WAIT phase of DUMMY cycles (PSRAM/flash fast read).
- Undefined: WAIT is removed and pull DATA follows ADDR directly (SRAM-style memory). Pull DATA occupies cycles 9-16, `wstrobe_d` is high in cycles 10-17, and DONE is cycle 17. The DUMMY parameter is ignored.

## Test plan
- Pull of tag 0x12345, `q_in` driving 0xA,0xB,...,0x1 -> memory sees:
  - command nibbles E,B;
  - address nibbles 0,4,8,D,1,4;
  - `dread` A..1 on 8 contiguous `wstrobe_d` cycles 16-23;
  - `done` in cycle 23.
- Push of tag 0x00001 with cache line 0x44332211 -> memory sees:
  - command nibbles 3,8;
  - address 0,0,0,0,0,4;
  - `q_out` 1,1,2,2,3,3,4,4 with `q_oe`=1;
  - 8 contiguous `rstrobe_d` pulses;
  - `done` at cycle 17.
- `req` with `push`=`pull`=0 -> `busy` stays 0 and `q_cs_n` stays 1. `req` held high during a transfer -> exactly one transfer completes.
- `reset`=0 at cycle 12 of a pull -> the next cycle shows IDLE, `q_cs_n`=1, no strobes and no `done`. A new pull then completes normally.
- Back-to-back push then pull: push `done`, then `req` one cycle later -> `q_cs_n` high for exactly 1 cycle between transfers.
- Build without `DLINE_XFER_DUMMY_EN` -> pull `done` at cycle 17 and the first `wstrobe_d` at cycle 10.
